// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int STEP_MAX = 7;
    localparam int DATA_W   = 8;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit barrel shifter, 0..7 positions per pass.
module barrel_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        shamt,
    input  logic              LR,
    input  logic              AL,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (LR) begin
            dout = din << shamt;
        end else if (AL) begin
            dout = DATA_W'($signed(din) >>> shamt);
        end else begin
            dout = din >> shamt;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Shift sequencer: splits a shift of up to 31 into passes of at most 7
// through a 3-bit barrel shifter, one pass per clock.
module shift_seq
    import shift_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [AMT_W-1:0]  amt,
    input  logic              lr,
    input  logic              al,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready and out_valid decode only from state; upstream holds its
    // request until accepted, and dout/out_valid stay stable until taken.

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc;
    logic [AMT_W-1:0]    rem;
    logic                lr_q, al_q;
    logic [2:0]          step;
    logic [AMT_W-1:0]    rem_next;
    logic [DATA_W-1:0]   shifted;

    assign step     = (rem > AMT_W'(STEP_MAX)) ? 3'(STEP_MAX) : rem[2:0];
    assign rem_next = rem - AMT_W'(step);

    barrel_shifter u_barrel (
        .din   (acc),
        .shamt (step),
        .LR    (lr_q),
        .AL    (al_q),
        .dout  (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (rem_next == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            rem  <= '0;
            lr_q <= 1'b0;
            al_q <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                acc  <= din;
                rem  <= amt;
                lr_q <= lr;
                al_q <= al;
            end else if (state_q == SHIFT) begin
                acc <= shifted;
                rem <= rem_next;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign dout      = acc;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: results, latency, backpressure and reset.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] din = 8'h00;
    logic [4:0] amt = 5'd0;
    logic       lr = 1'b0;
    logic       al = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] dout;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    shift_seq #(.AMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .amt       (amt),
        .lr        (lr),
        .al        (al),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    // Present a request and hold it across one edge (block assumed in IDLE).
    task automatic do_accept(input logic [7:0] d, input logic [4:0] a,
                             input logic l, input logic s);
        din = d; amt = a; lr = l; al = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done(output int k);
        k = 1;
        @(posedge clk); #1;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_left();
        int k;
        do_accept(8'h96, 5'd3, 1'b1, 1'b0);
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL left_busy_shift got busy=%b in_ready=%b want 1/0", busy, in_ready); else pass_cnt++;
        wait_done(k);
        total_cnt++; if (k !== 1) $display("FAIL left_latency got %0d want 1", k); else pass_cnt++;
        total_cnt++; if (dout !== 8'hB0) $display("FAIL left_dout got %h want b0", dout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL left_busy_done got %b want 1", busy); else pass_cnt++;
        take();
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL left_idle got busy=%b in_ready=%b want 0/1", busy, in_ready); else pass_cnt++;
    endtask

    task automatic test_arith_multi();
        int k;
        do_accept(8'h96, 5'd10, 1'b0, 1'b1);
        wait_done(k);
        total_cnt++; if (k !== 2) $display("FAIL asr10_neg_latency got %0d want 2", k); else pass_cnt++;
        total_cnt++; if (dout !== 8'hFF) $display("FAIL asr10_neg_dout got %h want ff", dout); else pass_cnt++;
        take();
        do_accept(8'h56, 5'd10, 1'b0, 1'b1);
        wait_done(k);
        total_cnt++; if (k !== 2) $display("FAIL asr10_pos_latency got %0d want 2", k); else pass_cnt++;
        total_cnt++; if (dout !== 8'h00) $display("FAIL asr10_pos_dout got %h want 00", dout); else pass_cnt++;
        take();
    endtask

    task automatic test_right();
        int k;
        do_accept(8'h96, 5'd4, 1'b0, 1'b0);
        wait_done(k);
        total_cnt++; if (dout !== 8'h09 || k !== 1) $display("FAIL lsr4 got %h k=%0d want 09 k=1", dout, k); else pass_cnt++;
        take();
        do_accept(8'h96, 5'd2, 1'b0, 1'b1);
        wait_done(k);
        total_cnt++; if (dout !== 8'hE5 || k !== 1) $display("FAIL asr2 got %h k=%0d want e5 k=1", dout, k); else pass_cnt++;
        take();
        // lr=1 must ignore al
        do_accept(8'h96, 5'd1, 1'b1, 1'b1);
        wait_done(k);
        total_cnt++; if (dout !== 8'h2C) $display("FAIL shl1_al_ignored got %h want 2c", dout); else pass_cnt++;
        take();
    endtask

    task automatic test_extremes();
        int k;
        do_accept(8'h96, 5'd0, 1'b1, 1'b0);
        wait_done(k);
        total_cnt++; if (dout !== 8'h96 || k !== 1) $display("FAIL amt0 got %h k=%0d want 96 k=1", dout, k); else pass_cnt++;
        take();
        do_accept(8'h96, 5'd31, 1'b1, 1'b0);
        wait_done(k);
        total_cnt++; if (dout !== 8'h00 || k !== 5) $display("FAIL amt31_shl got %h k=%0d want 00 k=5", dout, k); else pass_cnt++;
        take();
        do_accept(8'h81, 5'd14, 1'b0, 1'b1);
        wait_done(k);
        total_cnt++; if (dout !== 8'hFF || k !== 2) $display("FAIL amt14_asr got %h k=%0d want ff k=2", dout, k); else pass_cnt++;
        take();
        do_accept(8'hC3, 5'd8, 1'b0, 1'b0);
        wait_done(k);
        total_cnt++; if (dout !== 8'h00 || k !== 2) $display("FAIL amt8_lsr got %h k=%0d want 00 k=2", dout, k); else pass_cnt++;
        take();
    endtask

    task automatic test_back_to_back();
        int k;
        do_accept(8'h96, 5'd3, 1'b1, 1'b0);
        wait_done(k);
        din = 8'h96; amt = 5'd4; lr = 1'b0; al = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (dout !== 8'hB0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got dout=%h ov=%b ir=%b want b0/1/0", i, dout, out_valid, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_accept got busy=%b ir=%b want 1/0", busy, in_ready); else pass_cnt++;
        wait_done(k);
        total_cnt++; if (dout !== 8'h09 || k !== 1) $display("FAIL bp_second got %h k=%0d want 09 k=1", dout, k); else pass_cnt++;
        take();
    endtask

    task automatic test_reset_mid();
        int k;
        logic seen_ov;
        do_accept(8'hFF, 5'd31, 1'b1, 1'b0);
        // inputs changed after accept must not matter
        din = 8'h00; amt = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || dout !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_immediate got ov=%b dout=%h busy=%b ir=%b want 0/00/0/1", out_valid, dout, busy, in_ready); else pass_cnt++;
        seen_ov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1'b1;
        end
        total_cnt++; if (seen_ov !== 1'b0) $display("FAIL rstmid_no_output got out_valid seen=%b want 0", seen_ov); else pass_cnt++;
        #2 rst_n = 1'b1;
        do_accept(8'h96, 5'd2, 1'b0, 1'b1);
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_accept got busy=%b want 1", busy); else pass_cnt++;
        wait_done(k);
        total_cnt++; if (dout !== 8'hE5 || k !== 1) $display("FAIL rstmid_result got %h k=%0d want e5 k=1", dout, k); else pass_cnt++;
        take();
    endtask

    initial begin
        test_reset();
        test_left();
        test_arith_multi();
        test_right();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
